// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the pipeline controller.
//   fwd_e   - per-source operand forward select (register file / E result / M result)
//   stall_e - reason the front of the pipe is not advancing, exported for debug
//   ra_w()  - register-address width for a given register count
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_E   = 2'd1,
        FWD_M   = 2'd2
    } fwd_e;

    // Five causes need three bits.
    typedef enum logic [2:0] {
        NONE = 3'd0,
        BUSY = 3'd1,
        MISS = 3'd2,
        LOAD = 3'd3,
        SB   = 3'd4
    } stall_e;

    function automatic int ra_w(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard: one busy bit per architectural register for long-latency writers.
// Ports:
//   clk, rst            clock, synchronous active-high reset (clears every bit)
//   set_en, set_addr    mark a register busy from the next cycle on
//   clr_en, clr_addr    mark a register free from the next cycle on
//   look_addr           NLOOK packed lookup addresses, entry k at [k*RA_W +: RA_W]
//   look_busy           busy bit for each lookup address (register 0 always reads free)
module pipe_scoreboard
    import pipe_pkg::*;
#(
    parameter int NREG  = 64,
    parameter int NLOOK = 4,
    localparam int RA_W = ra_w(NREG)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en,
    input  logic [RA_W-1:0]       set_addr,
    input  logic                  clr_en,
    input  logic [RA_W-1:0]       clr_addr,
    input  logic [NLOOK*RA_W-1:0] look_addr,
    output logic [NLOOK-1:0]      look_busy
);

    logic [NREG-1:0] busy_q, busy_d;

    // Clear is applied first so a same-cycle set of the same register wins.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        look_busy = '0;
        for (int k = 0; k < NLOOK; k++) begin
            look_busy[k] = (look_addr[k*RA_W +: RA_W] != '0) && busy_q[look_addr[k*RA_W +: RA_W]];
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central controller for the F/D/E/M/W core.
// Owns the PC, per-stage load enables and flushes, load-use and scoreboard
// stalls, and per-source forwarding selects.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   dec_*                        decoded instruction in D (sources, dest, flags)
//   ex_*, mem_*                  destinations in E and M for forwarding / load-use
//   wb_valid, wb_rd, wb_long     retiring instruction, frees scoreboard entries
//   ex_busy, mem_busy            multi-cycle E unit / M memory wait
//   br_miss, br_target           redirect from E
//   fetch_pc                     imem address this cycle
//   f_en..w_en, d_flush, e_flush stage register controls
//   fwd_sel                      2 bits per source (fwd_e)
//   stall_cause                  stall_e debug code
// Build option PIPE_CTRL_PERF_EN adds 32-bit wrapping perf counters
// (perf_cycles, perf_load_stall, perf_sb_stall, perf_busy, perf_miss).
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int              NREG     = 64,
    parameter int              NSRC     = 3,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    localparam int             RA_W     = ra_w(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_valid,
    input  logic [NSRC*RA_W-1:0] dec_rs,
    input  logic [NSRC-1:0]      dec_rs_used,
    input  logic [RA_W-1:0]      dec_rd,
    input  logic                 dec_regwrite,
    input  logic                 dec_long,
    input  logic [RA_W-1:0]      ex_rd,
    input  logic                 ex_regwrite,
    input  logic                 ex_memread,
    input  logic [RA_W-1:0]      mem_rd,
    input  logic                 mem_regwrite,
    input  logic                 wb_valid,
    input  logic [RA_W-1:0]      wb_rd,
    input  logic                 wb_long,
    input  logic                 ex_busy,
    input  logic                 mem_busy,
    input  logic                 br_miss,
    input  logic [XLEN-1:0]      br_target,
    output logic [XLEN-1:0]      fetch_pc,
    output logic                 f_en,
    output logic                 d_en,
    output logic                 e_en,
    output logic                 m_en,
    output logic                 w_en,
    output logic                 d_flush,
    output logic                 e_flush,
    output logic [NSRC*2-1:0]    fwd_sel,
    output stall_e               stall_cause
`ifdef PIPE_CTRL_PERF_EN
   ,output logic [31:0]          perf_cycles,
    output logic [31:0]          perf_load_stall,
    output logic [31:0]          perf_sb_stall,
    output logic [31:0]          perf_busy,
    output logic [31:0]          perf_miss
`endif
);

    logic [XLEN-1:0]            pc_q, pc_d;
    logic [NSRC:0]              look_busy;
    logic [(NSRC+1)*RA_W-1:0]   look_addr;
    logic [NSRC*2-1:0]          fwd_raw;
    logic [RA_W-1:0]            rs;
    logic                       busy, lw_hit, sb_hit, lw_stall, sb_stall, go;
    stall_e                     cause;

    // Lookups 0..NSRC-1 are the sources, lookup NSRC is the destination (WAW).
    assign look_addr = {dec_rd, dec_rs};

    pipe_scoreboard #(
        .NREG  (NREG),
        .NLOOK (NSRC + 1)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .set_en    (e_en & dec_valid & dec_long & dec_regwrite),
        .set_addr  (dec_rd),
        .clr_en    (wb_valid & wb_long),
        .clr_addr  (wb_rd),
        .look_addr (look_addr),
        .look_busy (look_busy)
    );

    always_comb begin
        busy    = ex_busy | mem_busy;
        lw_hit  = 1'b0;
        sb_hit  = 1'b0;
        fwd_raw = '0;
        rs      = '0;
        for (int i = 0; i < NSRC; i++) begin
            rs = dec_rs[i*RA_W +: RA_W];
            // Register 0 and unused sources never forward or hazard.
            if (dec_rs_used[i] && rs != '0) begin
                if (ex_regwrite && ex_rd == rs)        fwd_raw[i*2 +: 2] = FWD_E;
                else if (mem_regwrite && mem_rd == rs) fwd_raw[i*2 +: 2] = FWD_M;
                if (ex_memread && ex_rd == rs) lw_hit = 1'b1;
                if (look_busy[i])              sb_hit = 1'b1;
            end
        end
        if (dec_regwrite && look_busy[NSRC]) sb_hit = 1'b1;
        lw_stall = dec_valid & lw_hit;
        sb_stall = dec_valid & sb_hit;
        go       = ~busy & ~br_miss & ~lw_stall & ~sb_stall;

        if (busy)          cause = BUSY;
        else if (br_miss)  cause = MISS;
        else if (lw_stall) cause = LOAD;
        else if (sb_stall) cause = SB;
        else               cause = NONE;
    end

    // Outputs are held in their quiet state while reset is asserted.
    always_comb begin
        f_en        = ~rst & go;
        d_en        = ~rst & go;
        e_en        = ~rst & go;
        m_en        = ~rst & ~busy;
        w_en        = ~rst & ~mem_busy;
        d_flush     = ~rst & br_miss & ~busy;
        e_flush     = ~rst & (br_miss | lw_stall | sb_stall) & ~busy;
        fwd_sel     = rst ? '0 : fwd_raw;
        stall_cause = rst ? NONE : cause;
        fetch_pc    = br_miss ? br_target : pc_q;
    end

    // The redirect target is fetched this cycle, so the PC continues after it.
    always_comb begin
        pc_d = pc_q;
        if (!busy) begin
            if (br_miss) pc_d = br_target + XLEN'(4);
            else if (go) pc_d = pc_q + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] cyc_q, load_q, sbc_q, busyc_q, miss_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cyc_q   <= '0;
            load_q  <= '0;
            sbc_q   <= '0;
            busyc_q <= '0;
            miss_q  <= '0;
        end else begin
            cyc_q <= cyc_q + 32'd1;
            if (cause == LOAD) load_q  <= load_q + 32'd1;
            if (cause == SB)   sbc_q   <= sbc_q + 32'd1;
            if (cause == BUSY) busyc_q <= busyc_q + 32'd1;
            if (cause == MISS) miss_q  <= miss_q + 32'd1;
        end
    end

    assign perf_cycles     = cyc_q;
    assign perf_load_stall = load_q;
    assign perf_sb_stall   = sbc_q;
    assign perf_busy       = busyc_q;
    assign perf_miss       = miss_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;
    import pipe_pkg::*;

    localparam int NSRC = 3;
    localparam int RA_W = 6;
    localparam int XLEN = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 dec_valid;
    logic [NSRC*RA_W-1:0] dec_rs;
    logic [NSRC-1:0]      dec_rs_used;
    logic [RA_W-1:0]      dec_rd;
    logic                 dec_regwrite, dec_long;
    logic [RA_W-1:0]      ex_rd;
    logic                 ex_regwrite, ex_memread;
    logic [RA_W-1:0]      mem_rd;
    logic                 mem_regwrite;
    logic                 wb_valid;
    logic [RA_W-1:0]      wb_rd;
    logic                 wb_long;
    logic                 ex_busy, mem_busy, br_miss;
    logic [XLEN-1:0]      br_target;
    logic [XLEN-1:0]      fetch_pc;
    logic                 f_en, d_en, e_en, m_en, w_en, d_flush, e_flush;
    logic [NSRC*2-1:0]    fwd_sel;
    stall_e               stall_cause;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_load_stall, perf_sb_stall, perf_busy, perf_miss;
`endif

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.NREG(64), .NSRC(NSRC), .XLEN(XLEN), .RESET_PC('0)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rs_used(dec_rs_used),
        .dec_rd(dec_rd), .dec_regwrite(dec_regwrite), .dec_long(dec_long),
        .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_long(wb_long),
        .ex_busy(ex_busy), .mem_busy(mem_busy),
        .br_miss(br_miss), .br_target(br_target),
        .fetch_pc(fetch_pc),
        .f_en(f_en), .d_en(d_en), .e_en(e_en), .m_en(m_en), .w_en(w_en),
        .d_flush(d_flush), .e_flush(e_flush),
        .fwd_sel(fwd_sel), .stall_cause(stall_cause)
`ifdef PIPE_CTRL_PERF_EN
       ,.perf_cycles(perf_cycles), .perf_load_stall(perf_load_stall),
        .perf_sb_stall(perf_sb_stall), .perf_busy(perf_busy), .perf_miss(perf_miss)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dec_valid = 0; dec_rs = '0; dec_rs_used = '0; dec_rd = '0;
        dec_regwrite = 0; dec_long = 0;
        ex_rd = '0; ex_regwrite = 0; ex_memread = 0;
        mem_rd = '0; mem_regwrite = 0;
        wb_valid = 0; wb_rd = '0; wb_long = 0;
        ex_busy = 0; mem_busy = 0; br_miss = 0; br_target = '0;
    endtask

    task automatic set_rs(input logic [RA_W-1:0] a0, input logic [RA_W-1:0] a1,
                          input logic [RA_W-1:0] a2, input logic [2:0] used);
        dec_rs = {a2, a1, a0};
        dec_rs_used = used;
    endtask

    // Advance one clock; inputs change and outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1;
        // Reset: outputs quiet even with a forwarding match on the inputs.
        ex_regwrite = 1; ex_rd = 5; dec_valid = 1; set_rs(5, 0, 0, 3'b001);
        step(); #1;
        chk("rst_f_en", 32'(f_en), 0);
        chk("rst_w_en", 32'(w_en), 0);
        chk("rst_e_flush", 32'(e_flush), 0);
        chk("rst_fwd", 32'(fwd_sel), 0);
        chk("rst_cause", 32'(stall_cause), 32'(NONE));
        chk("rst_pc", fetch_pc, 32'h0);

        // Forward from E and M on the same register: E wins; reg 0 stays REG.
        rst = 0; idle();
        dec_valid = 1; ex_rd = 5; ex_regwrite = 1; mem_rd = 5; mem_regwrite = 1;
        set_rs(5, 0, 6, 3'b111);
        #1;
        chk("fwd_both", 32'(fwd_sel), 32'h01);
        chk("fwd_f_en", 32'(f_en), 1);
        chk("fwd_pc0", fetch_pc, 32'h0);
        step();
        // M-only source and an unused matching source.
        mem_rd = 6; set_rs(5, 5, 6, 3'b101);
        #1;
        chk("fwd_m_unused", 32'(fwd_sel), 32'h21);
        chk("pc_inc", fetch_pc, 32'h4);
        step();

        // Load-use: one stall cycle, then M forward.
        idle(); dec_valid = 1; set_rs(0, 7, 0, 3'b010);
        ex_memread = 1; ex_rd = 7; ex_regwrite = 1;
        #1;
        chk("lu_f_en", 32'(f_en), 0);
        chk("lu_d_en", 32'(d_en), 0);
        chk("lu_e_en", 32'(e_en), 0);
        chk("lu_m_en", 32'(m_en), 1);
        chk("lu_e_flush", 32'(e_flush), 1);
        chk("lu_d_flush", 32'(d_flush), 0);
        chk("lu_cause", 32'(stall_cause), 32'(LOAD));
        chk("lu_pc", fetch_pc, 32'h8);
        step();
        ex_memread = 0; ex_regwrite = 0; ex_rd = 0; mem_rd = 7; mem_regwrite = 1;
        #1;
        chk("lu2_fwd", 32'(fwd_sel), 32'h08);
        chk("lu2_f_en", 32'(f_en), 1);
        chk("lu2_pc_held", fetch_pc, 32'h8);
        step();

        // Long op to r9, dependent stalls until retire, enables return the cycle after.
        idle(); dec_valid = 1; dec_long = 1; dec_regwrite = 1; dec_rd = 9;
        #1;
        chk("long_e_en", 32'(e_en), 1);
        step();
        idle(); dec_valid = 1; dec_regwrite = 1; dec_rd = 10; set_rs(9, 0, 0, 3'b001);
        #1;
        chk("sb_f_en", 32'(f_en), 0);
        chk("sb_cause", 32'(stall_cause), 32'(SB));
        chk("sb_e_flush", 32'(e_flush), 1);
        chk("sb_pc", fetch_pc, 32'h10);
        step();
        wb_valid = 1; wb_long = 1; wb_rd = 9;
        #1;
        chk("sb_clr_cycle", 32'(f_en), 0);
        step();
        wb_valid = 0; wb_long = 0; wb_rd = 0;
        #1;
        chk("sb_after_f_en", 32'(f_en), 1);
        chk("sb_after_cause", 32'(stall_cause), 32'(NONE));
        chk("sb_after_pc", fetch_pc, 32'h10);
        step();

        // Branch miss together with a load-use: MISS has priority.
        idle(); br_miss = 1; br_target = 32'h100;
        dec_valid = 1; set_rs(0, 7, 0, 3'b010); ex_memread = 1; ex_rd = 7; ex_regwrite = 1;
        #1;
        chk("miss_fetch", fetch_pc, 32'h100);
        chk("miss_d_flush", 32'(d_flush), 1);
        chk("miss_e_flush", 32'(e_flush), 1);
        chk("miss_f_en", 32'(f_en), 0);
        chk("miss_cause", 32'(stall_cause), 32'(MISS));
        step();
        idle();
        #1;
        chk("miss_next_pc", fetch_pc, 32'h104);
        step();

        // Busy holds everything, miss applied on release.
        idle(); mem_busy = 1; br_miss = 1; br_target = 32'h200;
        #1;
        chk("busy_f_en", 32'(f_en), 0);
        chk("busy_m_en", 32'(m_en), 0);
        chk("busy_w_en", 32'(w_en), 0);
        chk("busy_d_flush", 32'(d_flush), 0);
        chk("busy_e_flush", 32'(e_flush), 0);
        chk("busy_cause", 32'(stall_cause), 32'(BUSY));
        step();
        mem_busy = 0;
        #1;
        chk("rel_d_flush", 32'(d_flush), 1);
        chk("rel_cause", 32'(stall_cause), 32'(MISS));
        step();
        idle(); ex_busy = 1;
        #1;
        chk("rel_pc", fetch_pc, 32'h204);
        chk("exbusy_w_en", 32'(w_en), 1);
        chk("exbusy_m_en", 32'(m_en), 0);
        step();

        // Reset mid-op forgets the pending long op on r9.
        idle(); dec_valid = 1; dec_long = 1; dec_regwrite = 1; dec_rd = 9;
        step();
        chk("pre_rst_pc", fetch_pc, 32'h208);
        idle(); rst = 1;
        step();
        rst = 0; dec_valid = 1; set_rs(9, 0, 0, 3'b001);
        #1;
        chk("rst2_pc", fetch_pc, 32'h0);
        chk("rst2_f_en", 32'(f_en), 1);
        chk("rst2_cause", 32'(stall_cause), 32'(NONE));
`ifdef PIPE_CTRL_PERF_EN
        chk("perf_cycles0", perf_cycles, 0);
        chk("perf_load0", perf_load_stall, 0);
        chk("perf_sb0", perf_sb_stall, 0);
        chk("perf_busy0", perf_busy, 0);
        chk("perf_miss0", perf_miss, 0);
`endif
        step();

        // Set and clear of r20 in the same cycle: set wins.
        idle(); dec_valid = 1; dec_long = 1; dec_regwrite = 1; dec_rd = 20;
        wb_valid = 1; wb_long = 1; wb_rd = 20;
        step();
        idle(); dec_valid = 1; set_rs(20, 0, 0, 3'b001);
        #1;
        chk("setwins_cause", 32'(stall_cause), 32'(SB));
        // WAW on busy r20 with no sources.
        set_rs(0, 0, 0, 3'b000); dec_regwrite = 1; dec_rd = 20;
        #1;
        chk("waw_cause", 32'(stall_cause), 32'(SB));
        // Register 0 never hazards or forwards.
        idle(); dec_valid = 1; set_rs(0, 0, 0, 3'b111);
        ex_memread = 1; ex_rd = 0; ex_regwrite = 1;
        #1;
        chk("r0_fwd", 32'(fwd_sel), 0);
        chk("r0_f_en", 32'(f_en), 1);
        step();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
